// File: rtl/leg_gate_monitor.sv
// Gate read-back monitor for one two-switch leg: decodes applied switch state, measures dead times,
// latches shoot-through / dead-time faults. Optional macro GATE_SYNC_EN adds a 2-flop input synchronizer.
module leg_gate_monitor #(
  parameter int DT_W   = 8,
  parameter int MIN_DT = 10,
  parameter int MAX_DT = 200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      gate,
  input  logic            fault_clr,
  output logic [1:0]      leg_state,
  output logic            leg_valid,
  output logic [DT_W-1:0] dt_meas0,
  output logic            dt_valid0,
  output logic [DT_W-1:0] dt_meas1,
  output logic            dt_valid1,
  output logic            fault,
  output logic [5:0]      fault_code
);

  typedef enum logic [2:0] {
    ST_UNKNOWN = 3'd0,
    ST_ON_LO   = 3'd1,
    ST_ON_HI   = 3'd2,
    ST_DEAD    = 3'd3,
    ST_SHOOT   = 3'd4
  } pair_state_e;

  localparam logic [DT_W-1:0] MAX_C = DT_W'(MAX_DT);
  localparam logic [DT_W-1:0] MIN_C = DT_W'(MIN_DT);
  localparam logic [DT_W-1:0] ONE_C = DT_W'(1);

  function automatic pair_state_e decode_pair(input logic s, input logic ns);
    pair_state_e st;
    case ({s, ns})
      2'b10:   st = ST_ON_HI;
      2'b01:   st = ST_ON_LO;
      2'b00:   st = ST_DEAD;
      default: st = ST_SHOOT;
    endcase
    return st;
  endfunction

  function automatic logic is_on(input pair_state_e st);
    return (st == ST_ON_HI) || (st == ST_ON_LO);
  endfunction

  logic [3:0] g_q;
  logic       g_vld;

`ifdef GATE_SYNC_EN
  logic [3:0] gate_meta;
  logic       meta_vld;

  // Two-flop synchronizer for asynchronous feedback pins; valid flag tracks the fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_meta <= 4'b0000;
      meta_vld  <= 1'b0;
      g_q       <= 4'b0000;
      g_vld     <= 1'b0;
    end else begin
      gate_meta <= gate;
      meta_vld  <= 1'b1;
      g_q       <= gate_meta;
      g_vld     <= meta_vld;
    end
  end
`else
  // Single sample register for on-chip gate nets.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_q   <= 4'b0000;
      g_vld <= 1'b0;
    end else begin
      g_q   <= gate;
      g_vld <= 1'b1;
    end
  end
`endif

  pair_state_e     state_q [2];
  pair_state_e     state_d [2];
  logic [DT_W-1:0] cnt_q   [2];
  logic [DT_W-1:0] cnt_d   [2];
  logic [DT_W-1:0] meas_q  [2];
  logic [DT_W-1:0] meas_d  [2];
  logic [1:0]      strobe_q, strobe_d;
  logic [1:0]      leg_q, leg_d;
  logic            lv_q, lv_d;
  logic [5:0]      code_q, code_d, set_bits;
  logic            fault_q, fault_d;

  // Decode both pairs, run dead-time counters and build fault set bits.
  // The sample-valid flag keeps the reset value of g_q from looking like a real dead interval.
  always_comb begin
    pair_state_e cls;
    state_d  = state_q;
    cnt_d    = cnt_q;
    meas_d   = meas_q;
    strobe_d = 2'b00;
    leg_d    = leg_q;
    set_bits = 6'b000000;
    lv_d     = 1'b0;
    cls      = ST_UNKNOWN;
    if (g_vld) begin
      for (int p = 0; p < 2; p++) begin
        cls        = decode_pair(g_q[p], g_q[p+2]);
        state_d[p] = cls;
        case (cls)
          ST_DEAD: begin
            if (state_q[p] != ST_DEAD) begin
              cnt_d[p] = ONE_C;
            end else if (cnt_q[p] != MAX_C) begin
              cnt_d[p] = cnt_q[p] + ONE_C;
            end else begin
              cnt_d[p] = cnt_q[p];
            end
            if ((cnt_d[p] == MAX_C) && ((state_q[p] != ST_DEAD) || (cnt_q[p] != MAX_C))) begin
              set_bits[3*p+2] = 1'b1;
            end else begin
              set_bits[3*p+2] = 1'b0;
            end
          end
          ST_ON_HI, ST_ON_LO: begin
            leg_d[p] = (cls == ST_ON_HI);
            if (state_q[p] == ST_DEAD) begin
              meas_d[p]       = cnt_q[p];
              strobe_d[p]     = 1'b1;
              set_bits[3*p+1] = (cnt_q[p] < MIN_C);
            end else if (is_on(state_q[p]) && (state_q[p] != cls)) begin
              meas_d[p]       = {DT_W{1'b0}};
              strobe_d[p]     = 1'b1;
              set_bits[3*p+1] = 1'b1;
            end else begin
              strobe_d[p] = 1'b0;
            end
          end
          ST_SHOOT: begin
            set_bits[3*p] = 1'b1;
          end
          default: begin
            state_d[p] = ST_UNKNOWN;
          end
        endcase
      end
      lv_d = is_on(state_d[0]) && is_on(state_d[1]);
    end else begin
      lv_d = 1'b0;
    end
    if (fault_clr) begin
      code_d = set_bits;
    end else begin
      code_d = code_q | set_bits;
    end
    fault_d = |code_d;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= ST_UNKNOWN;
        cnt_q[p]   <= {DT_W{1'b0}};
        meas_q[p]  <= {DT_W{1'b0}};
      end
      strobe_q <= 2'b00;
      leg_q    <= 2'b00;
      lv_q     <= 1'b0;
      code_q   <= 6'b000000;
      fault_q  <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= state_d[p];
        cnt_q[p]   <= cnt_d[p];
        meas_q[p]  <= meas_d[p];
      end
      strobe_q <= strobe_d;
      leg_q    <= leg_d;
      lv_q     <= lv_d;
      code_q   <= code_d;
      fault_q  <= fault_d;
    end
  end

  assign leg_state  = leg_q;
  assign leg_valid  = lv_q;
  assign dt_meas0   = meas_q[0];
  assign dt_valid0  = strobe_q[0];
  assign dt_meas1   = meas_q[1];
  assign dt_valid1  = strobe_q[1];
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_leg_gate_monitor.sv
// Self-checking bench for leg_gate_monitor: directed scenarios with literal expectations
// plus randomized gate streams compared every cycle against a behavioural model.
module tb_leg_gate_monitor;

  localparam int DT_W   = 8;
  localparam int MIN_DT = 10;
  localparam int MAX_DT = 200;
`ifdef GATE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      gate;
  logic            fault_clr;
  logic [1:0]      leg_state;
  logic            leg_valid;
  logic [DT_W-1:0] dt_meas0, dt_meas1;
  logic            dt_valid0, dt_valid1;
  logic            fault;
  logic [5:0]      fault_code;

  int checks   = 0;
  int failures = 0;

  leg_gate_monitor #(.DT_W(DT_W), .MIN_DT(MIN_DT), .MAX_DT(MAX_DT)) dut (
    .clk(clk), .rst(rst), .gate(gate), .fault_clr(fault_clr),
    .leg_state(leg_state), .leg_valid(leg_valid),
    .dt_meas0(dt_meas0), .dt_valid0(dt_valid0),
    .dt_meas1(dt_meas1), .dt_valid1(dt_valid1),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // Model: per pair the previous applied class (-1 unknown, 0 low, 1 high, 2 dead, 3 shoot)
  // and the length of the current dead run in samples.
  int         m_prev [2];
  int         m_len  [2];
  int         e_meas [2];
  bit         e_vld  [2];
  bit [1:0]   e_leg;
  bit         e_lv;
  bit [5:0]   e_code;
  logic [3:0] pipe_g [$];
  bit         pipe_v [$];

  function automatic int classify(input logic [3:0] g, input int p);
    if (g[p] && g[p+2]) return 3;
    if (g[p]) return 1;
    if (g[p+2]) return 0;
    return 2;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_prev[p] = -1; m_len[p] = 0; e_meas[p] = 0; e_vld[p] = 1'b0;
    end
    e_leg = 2'b00; e_lv = 1'b0; e_code = 6'b000000;
    pipe_g.delete(); pipe_v.delete();
    for (int i = 0; i < LAT - 1; i++) begin
      pipe_g.push_back(4'b0000); pipe_v.push_back(1'b0);
    end
  endtask

  task automatic model_edge(input logic r, input logic [3:0] g, input logic clr);
    logic [3:0] cg;
    bit         cv;
    bit [5:0]   set;
    int         cls [2];
    e_vld[0] = 1'b0; e_vld[1] = 1'b0;
    if (r) begin
      model_reset();
      return;
    end
    cg = pipe_g.pop_front(); cv = pipe_v.pop_front();
    pipe_g.push_back(g); pipe_v.push_back(1'b1);
    set = 6'b000000;
    if (cv) begin
      for (int p = 0; p < 2; p++) begin
        cls[p] = classify(cg, p);
        if (cls[p] == 2) begin
          m_len[p] = (m_prev[p] == 2) ? m_len[p] + 1 : 1;
          if (m_len[p] == MAX_DT) set[3*p+2] = 1'b1;
        end else if (cls[p] <= 1) begin
          e_leg[p] = cls[p][0];
          if (m_prev[p] == 2) begin
            e_meas[p] = (m_len[p] > MAX_DT) ? MAX_DT : m_len[p];
            e_vld[p]  = 1'b1;
            if (e_meas[p] < MIN_DT) set[3*p+1] = 1'b1;
          end else if ((m_prev[p] == 0 || m_prev[p] == 1) && m_prev[p] != cls[p]) begin
            e_meas[p] = 0; e_vld[p] = 1'b1; set[3*p+1] = 1'b1;
          end
        end else begin
          set[3*p] = 1'b1;
        end
        m_prev[p] = cls[p];
      end
      e_lv = (cls[0] <= 1) && (cls[1] <= 1);
    end else begin
      e_lv = 1'b0;
    end
    e_code = (clr ? 6'b000000 : e_code) | set;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    check("leg_state", leg_state, e_leg);
    check("leg_valid", leg_valid, e_lv);
    check("dt_meas0", dt_meas0, e_meas[0]);
    check("dt_valid0", dt_valid0, e_vld[0]);
    check("dt_meas1", dt_meas1, e_meas[1]);
    check("dt_valid1", dt_valid1, e_vld[1]);
    check("fault_code", fault_code, e_code);
    check("fault", fault, |e_code);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(rst, gate, fault_clr);
    @(negedge clk);
    compare_model();
  endtask

  int       hold [2];
  bit [1:0] pat  [2];

  initial begin
    model_reset();
    rst = 1'b1; gate = 4'b0110; fault_clr = 1'b0;
    repeat (3) tick();
    check("rst_outputs", {leg_state, leg_valid, dt_valid0, dt_valid1, fault, fault_code}, 0);
    rst = 1'b0;
    // pair0 low, pair1 high; then 12-cycle dead gap on pair0 into high
    repeat (5) tick();
    gate = 4'b0010;
    repeat (12) tick();
    gate = 4'b0011;
    repeat (LAT - 1) tick();
    check("t1_pre_valid", dt_valid0, 0);
    tick();
    check("t1_valid", dt_valid0, 1);
    check("t1_meas", dt_meas0, 12);
    check("t1_fault", fault, 0);
    check("t1_leg", leg_state, 2'b11);
    check("t1_lv", leg_valid, 1);
    // pair1 high -> 4-cycle dead -> low: short fault
    repeat (3) tick();
    gate = 4'b0001;
    repeat (4) tick();
    gate = 4'b1001;
    repeat (LAT) tick();
    check("t2_valid", dt_valid1, 1);
    check("t2_meas", dt_meas1, 4);
    check("t2_code", fault_code, 6'b010000);
    check("t2_fault", fault, 1);
    // clear, then single-cycle shoot on pair0
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("t3_clr", fault_code, 0);
    gate = 4'b1101; tick();
    gate = 4'b1001;
    repeat (LAT - 1) tick();
    check("t3_shoot", fault_code, 6'b000001);
    check("t3_no_valid_a", dt_valid0, 0);
    tick();
    check("t3_no_valid_b", dt_valid0, 0);
    // persistent shoot beats a simultaneous clear
    gate = 4'b1101;
    repeat (LAT) tick();
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("t3_clr_lose", fault_code[0], 1);
    gate = 4'b1001;
    repeat (LAT) tick();
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("t3_clr_win", fault_code, 0);
    // 250-cycle dead on pair0: long fault after 200 samples, saturated measurement
    gate = 4'b1000;
    repeat (LAT - 1 + 199) tick();
    check("t4_pre_long", fault_code[2], 0);
    tick();
    check("t4_long", fault_code[2], 1);
    repeat (250 - (LAT + 199)) tick();
    check("t4_no_valid", dt_valid0, 0);
    gate = 4'b1100;
    repeat (LAT) tick();
    check("t4_valid", dt_valid0, 1);
    check("t4_meas", dt_meas0, 200);
    check("t4_code", fault_code, 6'b000100);
    // reset mid-dead, release into both pairs driven
    gate = 4'b1000;
    repeat (5) tick();
    rst = 1'b1; repeat (2) tick();
    check("t5_rst", {leg_state, leg_valid, dt_meas0, dt_valid0, fault, fault_code}, 0);
    rst = 1'b0; gate = 4'b0110;
    repeat (LAT - 1) tick();
    check("t5_pre_lv", leg_valid, 0);
    tick();
    check("t5_lv", leg_valid, 1);
    check("t5_no_valid", dt_valid0, 0);
    check("t5_fault", fault, 0);
    // randomized streams
    hold[0] = 0; hold[1] = 0; pat[0] = 2'b10; pat[1] = 2'b01;
    for (int n = 0; n < 4000; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (hold[p] == 0) begin
          int r;
          r = $urandom_range(0, 99);
          if (r < 40) begin
            pat[p] = 2'b10; hold[p] = $urandom_range(1, 20);
          end else if (r < 80) begin
            pat[p] = 2'b01; hold[p] = $urandom_range(1, 20);
          end else if (r < 97) begin
            pat[p] = 2'b00;
            hold[p] = ($urandom_range(0, 15) == 0) ? $urandom_range(190, 215) : $urandom_range(1, 25);
          end else begin
            pat[p] = 2'b11; hold[p] = $urandom_range(1, 3);
          end
        end
        hold[p]--;
      end
      gate = {pat[1][0], pat[0][0], pat[1][1], pat[0][1]};
      rst = ($urandom_range(0, 699) == 0);
      fault_clr = ($urandom_range(0, 39) == 0);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
